lcd_char_receiver: RTL

//  Receiving end of the write-only 8-bit HD44780-style character-LCD bus that our lcd_driver produces.

---
 rtl/lcd_char_receiver_if.sv | 29 ++
 rtl/lcd_char_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_receiver_if.sv
// lcd_char_receiver_if: the 8-bit HD44780-style character-LCD bus.
// The master (lcd_driver or a testbench) drives the strobes and write data.
// The slave (lcd_char_receiver) drives the read-back data and its output enable.
interface lcd_char_receiver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic [7:0] lcd_dout;
  logic       lcd_doe;

  modport master (
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_data,
    input  lcd_dout,
    input  lcd_doe
  );

  modport slave (
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_data,
    output lcd_dout,
    output lcd_doe
  );
endinterface

// File: rtl/lcd_char_receiver.sv
// lcd_char_receiver: the receiving end of the write-only HD44780-style LCD bus.
// It decodes bus strobes into a 2x16 DDRAM image (index {line, col}) and the
// display state, and models the controller busy time.
// It counts protocol violations, which are strobes that arrive while the model is busy.
// Optional read-back path: define LCD_READBACK_EN to drive lcd_dout/lcd_doe and
// honour rw=1 strobes. Without it, rw=1 strobes are ignored and both outputs are 0.
module lcd_char_receiver #(
  parameter int BUSY_CYCLES = 50,
  parameter int CLR_CYCLES  = 1600
) (
  input  logic                       clk,
  input  logic                       rst,
  lcd_char_receiver_if.slave         bus,
  input  logic [4:0]                 rd_addr,
  output logic [7:0]                 rd_data,
  output logic [4:0]                 cursor,
  output logic                       disp_on,
  output logic                       busy,
  output logic                       wr_pulse,
  output logic [7:0]                 viol_cnt
);

  // The clear sweep takes 32 clocks, so the BUSY tail after a clear makes up
  // the rest of CLR_CYCLES. The tail is clamped so a small CLR_CYCLES cannot underflow.
  localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES);
  localparam logic [15:0] CLR_LOAD  = (CLR_CYCLES >= 32) ? 16'(CLR_CYCLES - 32) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_CLEAR = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t      state;
  logic        e_q;
  logic        rs_q;
  logic        rw_q;
  logic [7:0]  d_q;
  logic        e_fall;
  logic        strobe_counts;
  logic        cmd_rs;
  logic [7:0]  cmd_data;
  logic        inc_dir;
  logic [4:0]  clr_idx;
  logic [15:0] cnt;

  logic [7:0]  ddram [0:31];
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;

  // A bus cycle ends on the falling edge of e. At that edge, rs/rw/data are the
  // values from the last clock in which e was high.
  assign e_fall = e_q & ~bus.lcd_e;

  // Moves the cursor one cell in the current entry direction, wrapping modulo 32.
  function automatic logic [4:0] step_cursor(input logic [4:0] c, input logic inc);
    return inc ? (c + 5'd1) : (c - 5'd1);
  endfunction

`ifdef LCD_READBACK_EN
  logic [7:0] dout_q;
  logic       doe_q;

  // Every strobe counts as a violation while busy, because reads are also live transfers.
  assign strobe_counts = 1'b1;

  // Read-back drivers. Data is valid from the clock after e rises and is held
  // for as long as a read strobe stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 8'h00;
      doe_q  <= 1'b0;
    end else begin
      doe_q  <= bus.lcd_e & bus.lcd_rw;
      dout_q <= bus.lcd_rs ? ddram[cursor] : {busy, 2'b00, cursor};
    end
  end

  assign bus.lcd_dout = dout_q;
  assign bus.lcd_doe  = doe_q;
`else
  // rw=1 strobes do not exist for this build, so only write strobes can violate timing.
  assign strobe_counts = ~rw_q;

  assign bus.lcd_dout = 8'h00;
  assign bus.lcd_doe  = 1'b0;
`endif

  // Register the enable strobe every clock. The other bus signals are captured
  // only while e is high, so they still hold their values when e falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q  <= 1'b0;
      rs_q <= 1'b0;
      rw_q <= 1'b0;
      d_q  <= 8'h00;
    end else begin
      e_q <= bus.lcd_e;
      if (bus.lcd_e) begin
        rs_q <= bus.lcd_rs;
        rw_q <= bus.lcd_rw;
        d_q  <= bus.lcd_data;
      end
    end
  end

  // DDRAM write port. The clear sweep and data writes never overlap, because they
  // come from different FSM states. Writes are held off during reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cursor;
    mem_wdata = cmd_data;
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx;
        mem_wdata = 8'h20;
      end else if (state == S_EXEC && cmd_rs) begin
        mem_we = 1'b1;
      end
    end
  end

  // DDRAM storage. It has no reset because the CLEAR sweep initialises every cell.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ddram[mem_addr] <= mem_wdata;
    end
  end

  // Always-live read port with one clock of registered latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= ddram[rd_addr];
    end
  end

  // Controller FSM. It accepts strobes, decodes them and models the busy time.
  // It also keeps the cursor, display and entry-mode state and the violation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_idx  <= 5'd0;
      cnt      <= 16'd0;
      cursor   <= 5'd0;
      disp_on  <= 1'b0;
      inc_dir  <= 1'b1;
      busy     <= 1'b1;
      wr_pulse <= 1'b0;
      viol_cnt <= 8'h00;
      cmd_rs   <= 1'b0;
      cmd_data <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;

      if (e_fall && state != S_IDLE && strobe_counts && viol_cnt != 8'hff) begin
        viol_cnt <= viol_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (e_fall && !rw_q) begin
            cmd_rs   <= rs_q;
            cmd_data <= d_q;
            wr_pulse <= rs_q;
            busy     <= 1'b1;
            state    <= S_EXEC;
          end
`ifdef LCD_READBACK_EN
          else if (e_fall && rw_q && rs_q) begin
            cursor <= step_cursor(cursor, inc_dir);
          end
`endif
        end

        S_EXEC: begin
          state <= S_BUSY;
          cnt   <= BUSY_LOAD;
          if (cmd_rs) begin
            cursor <= step_cursor(cursor, inc_dir);
          end else if (cmd_data[7]) begin
            cursor <= {cmd_data[6], cmd_data[3:0]};
          end else if (cmd_data[6] || cmd_data[5]) begin
            cursor <= cursor;
          end else if (cmd_data[4]) begin
            if (!cmd_data[3]) begin
              cursor <= step_cursor(cursor, cmd_data[2]);
            end
          end else if (cmd_data[3]) begin
            disp_on <= cmd_data[2];
          end else if (cmd_data[2]) begin
            inc_dir <= cmd_data[1];
          end else if (cmd_data[1]) begin
            cursor <= 5'd0;
          end else if (cmd_data[0]) begin
            clr_idx <= 5'd0;
            state   <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          cursor  <= 5'd0;
          inc_dir <= 1'b1;
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            cnt   <= CLR_LOAD;
            state <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (cnt == 16'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        default: begin
          clr_idx <= 5'd0;
          busy    <= 1'b1;
          state   <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
